// File: rtl/execute_memory_pipe_pkg.sv
// Shared definitions for the execute/memory boundary.
// The ALU and decode use the same opcode constants. This package also holds the
// entry record width helper and the buffer occupancy state encoding.
package execute_memory_pipe_pkg;

  localparam int unsigned ALU_OP_BITS = 6;
  localparam int unsigned REG_BITS    = 5;
  localparam int unsigned CTRL_BITS   = 3;  // regWrite, memRead, memWrite

  typedef enum logic [ALU_OP_BITS-1:0] {
    ALU_ADD  = 6'd0,
    ALU_JAL  = 6'd1,
    ALU_BEQ  = 6'd2,
    ALU_BNE  = 6'd3,
    ALU_BLT  = 6'd4,
    ALU_BGE  = 6'd5,
    ALU_BLTU = 6'd6,
    ALU_BGEU = 6'd7,
    ALU_SUB  = 6'd14
  } alu_op_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Entry record layout: {ALU_result, store_data, PC, rd, regWrite, memRead, memWrite}
  function automatic int unsigned entry_bits(input int unsigned data_width,
                                             input int unsigned address_bits);
    return 2 * data_width + address_bits + REG_BITS + CTRL_BITS;
  endfunction

endpackage

// File: rtl/execute_memory_pipe_if.sv
// Bundle of the handshake and data signals around the execute/memory pipe.
// master: the environment side. It drives the entries, flush and out_ready.
// slave : the pipe. It drives in_ready, out_* and redirect_*.
interface execute_memory_pipe_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20
);
  logic                    in_valid;
  logic                    in_ready;
  logic [5:0]              ALU_operation;
  logic [DATA_WIDTH-1:0]   ALU_result;
  logic                    is_branch;
  logic [ADDRESS_BITS-1:0] branch_target;
  logic [ADDRESS_BITS-1:0] PC;
  logic [4:0]              rd;
  logic                    regWrite;
  logic                    memRead;
  logic                    memWrite;
  logic [DATA_WIDTH-1:0]   store_data;
  logic                    flush;

  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_ALU_result;
  logic [DATA_WIDTH-1:0]   out_store_data;
  logic [ADDRESS_BITS-1:0] out_PC;
  logic [4:0]              out_rd;
  logic                    out_regWrite;
  logic                    out_memRead;
  logic                    out_memWrite;

  logic                    redirect_valid;
  logic [ADDRESS_BITS-1:0] redirect_target;

  modport master (
    output in_valid, ALU_operation, ALU_result, is_branch, branch_target, PC, rd,
           regWrite, memRead, memWrite, store_data, flush, out_ready,
    input  in_ready, out_valid, out_ALU_result, out_store_data, out_PC, out_rd,
           out_regWrite, out_memRead, out_memWrite, redirect_valid, redirect_target
  );

  modport slave (
    input  in_valid, ALU_operation, ALU_result, is_branch, branch_target, PC, rd,
           regWrite, memRead, memWrite, store_data, flush, out_ready,
    output in_ready, out_valid, out_ALU_result, out_store_data, out_PC, out_rd,
           out_regWrite, out_memRead, out_memWrite, redirect_valid, redirect_target
  );
endinterface

// File: rtl/execute_memory_pipe_skid_buffer.sv
// pipe_skid_buffer: a two-entry valid/ready buffer for an opaque payload.
// The main register drives out_data. The skid register catches one extra entry,
// so in_ready comes only from the occupancy register and never from out_ready.
// Ports: clock, reset (sync, active-high), flush (drop everything),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream).
module pipe_skid_buffer
  import execute_memory_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             load_main_in, load_main_skid, load_skid;
  logic             accept, pop;

  assign in_ready  = (state_q != BUF_TWO);
  assign out_valid = (state_q != BUF_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in)
        main_q <= in_data;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_data;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            state_d      = BUF_ONE;
            load_main_in = 1'b1;
          end
        end
        BUF_ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = BUF_TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          // in_ready is low here, so the only possible event is a pop.
          if (pop) begin
            state_d        = BUF_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/execute_memory_pipe.sv
// execute_memory_pipe: the register stage between execute and memory.
// Entries go through a two-entry skid buffer. A branch is resolved when its entry
// is accepted, and a taken branch gives a one-cycle fetch redirect pulse.
// Ports: clock, reset (sync, active-high), bus (slave modport). The bus carries the
// upstream entry fields, flush, the downstream out_* fields and redirect_valid/target.
module execute_memory_pipe
  import execute_memory_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20
) (
  input logic                   clock,
  input logic                   reset,
  execute_memory_pipe_if.slave  bus
);

  localparam int unsigned ENTRY_W = entry_bits(DATA_WIDTH, ADDRESS_BITS);

  logic [ENTRY_W-1:0]      in_entry, out_entry;
  logic                    accept, taken;
  logic                    redirect_valid_q;
  logic [ADDRESS_BITS-1:0] redirect_target_q;

  assign in_entry = {bus.ALU_result, bus.store_data, bus.PC, bus.rd,
                     bus.regWrite, bus.memRead, bus.memWrite};

  pipe_skid_buffer #(
    .WIDTH (ENTRY_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_entry)
  );

  assign {bus.out_ALU_result, bus.out_store_data, bus.out_PC, bus.out_rd,
          bus.out_regWrite, bus.out_memRead, bus.out_memWrite} = out_entry;

  // JAL is always taken. The conditional branches use bit 0 of the ALU compare result.
  assign accept = bus.in_valid && bus.in_ready;
  assign taken  = bus.is_branch &&
                  ((bus.ALU_operation == ALU_JAL) ||
                   ((bus.ALU_operation >= ALU_BEQ) && (bus.ALU_operation <= ALU_BGEU) &&
                    bus.ALU_result[0]));

  // A pulse already on the output in a flush cycle is not touched. Flush only
  // stops the incoming entry from starting a new pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
    end else if (!bus.flush && accept && taken) begin
      redirect_valid_q  <= 1'b1;
      redirect_target_q <= bus.branch_target;
    end else begin
      redirect_valid_q  <= 1'b0;
    end
  end

  assign bus.redirect_valid  = redirect_valid_q;
  assign bus.redirect_target = redirect_target_q;

endmodule

// File: tb/tb_execute_memory_pipe.sv
module tb_execute_memory_pipe;

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [19:0] pc;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  execute_memory_pipe_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) bus ();

  execute_memory_pipe #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // Reference model: ordered list of held entries plus expected redirect state.
  ent_t        q[$];
  logic        m_rv     = 1'b0;
  logic [19:0] m_rt     = '0;
  logic        m_zero   = 1'b1;
  logic        last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_taken(input logic br, input logic [5:0] op, input logic [31:0] res);
    if (!br) return 1'b0;
    if (op == 6'd1) return 1'b1;
    if (op >= 6'd2 && op <= 6'd7) return res[0];
    return 1'b0;
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] res,
                       input logic br, input logic [19:0] bt);
    bus.in_valid      = v;
    bus.ALU_operation = op;
    bus.ALU_result    = res;
    bus.is_branch     = br;
    bus.branch_target = bt;
    bus.PC            = 20'($urandom);
    bus.rd            = 5'($urandom);
    bus.regWrite      = 1'($urandom);
    bus.memRead       = 1'($urandom);
    bus.memWrite      = 1'($urandom);
    bus.store_data    = $urandom;
  endtask

  // One clock: predict from the current inputs, advance, then compare at negedge.
  task automatic tick();
    logic acc, pp, tk;
    ent_t e;
    acc = bus.in_valid && (q.size() < 2);
    pp  = (q.size() > 0) && bus.out_ready;
    tk  = model_taken(bus.is_branch, bus.ALU_operation, bus.ALU_result);
    e.res = bus.ALU_result; e.sd = bus.store_data; e.pc = bus.PC; e.rd = bus.rd;
    e.rw = bus.regWrite; e.mr = bus.memRead; e.mw = bus.memWrite;
    @(posedge clock);
    last_acc = 1'b0;
    if (reset) begin
      q.delete(); m_rv = 1'b0; m_rt = '0; m_zero = 1'b1;
    end else if (bus.flush) begin
      q.delete(); m_rv = 1'b0;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        m_zero   = 1'b0;
        last_acc = 1'b1;
      end
      m_rv = acc && tk;
      if (acc && tk) m_rt = bus.branch_target;
    end
    @(negedge clock);
    check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
    check("redirect_valid", 64'(bus.redirect_valid), 64'(m_rv));
    check("redirect_target", 64'(bus.redirect_target), 64'(m_rt));
    if (q.size() > 0) begin
      check("out_ALU_result", 64'(bus.out_ALU_result), 64'(q[0].res));
      check("out_store_data", 64'(bus.out_store_data), 64'(q[0].sd));
      check("out_PC", 64'(bus.out_PC), 64'(q[0].pc));
      check("out_rd", 64'(bus.out_rd), 64'(q[0].rd));
      check("out_ctrl", 64'({bus.out_regWrite, bus.out_memRead, bus.out_memWrite}),
            64'({q[0].rw, q[0].mr, q[0].mw}));
    end else if (m_zero) begin
      check("reset_data", 64'({bus.out_ALU_result, bus.out_store_data}), 64'(0));
      check("reset_pc_rd", 64'({bus.out_PC, bus.out_rd, bus.out_regWrite,
                                bus.out_memRead, bus.out_memWrite}), 64'(0));
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      drive(1'b0, 6'd0, '0, 1'b0, '0);
      tick();
    end
  endtask

  initial begin
    int unsigned k, waited;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 6'd1, 32'h1, 1'b1, 20'h123);
    bus.flush = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus.flush = 1'b0;
    idle(1);

    // Streaming: eight back-to-back entries
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      drive(1'b1, 6'd0, 32'h10 + i, 1'b0, '0);
      tick();
      check("stream_accept", 64'(last_acc), 64'(1));
    end
    idle(2);

    // Backpressure: three entries offered while the output is stalled
    bus.out_ready = 1'b0;
    k = 0;
    for (int unsigned c = 0; c < 4; c++) begin
      drive(1'b1, 6'd0, 32'h20 + k, 1'b0, '0);
      tick();
      if (last_acc) k++;
    end
    check("bp_accepted", 64'(k), 64'(2));
    bus.out_ready = 1'b1;
    waited = 0;
    do begin
      drive(1'b1, 6'd0, 32'h22, 1'b0, '0);
      tick();
      waited++;
    end while (!last_acc && waited < 4);
    check("bp_release_cycles", 64'(waited), 64'(2));
    idle(3);

    // Branch resolution
    drive(1'b1, 6'd2, 32'h1, 1'b1, 20'h00400); tick();
    check("beq_pulse", 64'(bus.redirect_valid), 64'(1));
    idle(1);
    check("beq_pulse_end", 64'(bus.redirect_valid), 64'(0));
    drive(1'b1, 6'd3, 32'h0, 1'b1, 20'h00800); tick();
    check("bne_no_pulse", 64'(bus.redirect_valid), 64'(0));
    drive(1'b1, 6'd1, 32'h0, 1'b1, 20'h00c00); tick();
    check("jal_pulse", 64'(bus.redirect_valid), 64'(1));
    idle(2);

    // Flush with two entries held and a taken BEQ offered
    bus.out_ready = 1'b0;
    drive(1'b1, 6'd0, 32'h30, 1'b0, '0); tick();
    drive(1'b1, 6'd0, 32'h31, 1'b0, '0); tick();
    drive(1'b1, 6'd2, 32'h1, 1'b1, 20'h00400);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_no_pulse", 64'(bus.redirect_valid), 64'(0));
    bus.out_ready = 1'b1;
    idle(3);

    // Reset while stalled with two entries held
    bus.out_ready = 1'b0;
    drive(1'b1, 6'd0, 32'h40, 1'b0, '0); tick();
    drive(1'b1, 6'd1, 32'h41, 1'b1, 20'h0abcd); tick();
    reset = 1'b1;
    drive(1'b1, 6'd1, 32'h42, 1'b1, 20'h01111);
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);

    // Randomized traffic
    for (int unsigned i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 15)), $urandom,
            1'($urandom), 20'($urandom));
      bus.out_ready = 1'($urandom_range(0, 4) > 1);
      bus.flush     = ($urandom_range(0, 29) == 0);
      reset         = ($urandom_range(0, 59) == 0);
      tick();
    end
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/execute_memory_pipe.md
EXECUTE_MEMORY_PIPE -- requirements
Module: execute_memory_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the ALU result and store data width.
REQ-002 SHALL have parameter ADDRESS_BITS, default 20, the PC and branch target width.
REQ-003 SHALL use one clock; reset is synchronous and active-high: clock  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-004 SHALL have ports:
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  this block can accept an entry.
- ALU_operation  input  6  ALU opcode of the entry.
- ALU_result  input  DATA_WIDTH  ALU output for the entry.
- is_branch  input  1  entry is a branch or jump.
- branch_target  input  ADDRESS_BITS  resolved target address.
- PC  input  ADDRESS_BITS  entry PC.
- rd  input  5  destination register.
- regWrite, memRead, memWrite  input  1 each  control bits.
- store_data  input  DATA_WIDTH  rs2 value for stores.
- flush  input  1  discard all held and incoming entries.
- out_valid  output  1  memory-stage entry valid.
- out_ready  input  1  memory stage accepts.
- out_ALU_result, out_store_data  output  DATA_WIDTH  registered copies.
- out_PC  output  ADDRESS_BITS; out_rd  output  5; out_regWrite, out_memRead, out_memWrite  output  1 each.
- redirect_valid  output  1  one-cycle taken-branch pulse.
- redirect_target  output  ADDRESS_BITS  fetch redirect address.

Function
REQ-005 SHALL hold entries in a two-entry buffer: a main register driving out_* and a skid register, with states EMPTY, ONE and TWO.
REQ-006 SHALL accept an entry when in_valid && in_ready; SHALL pop an entry when out_valid && out_ready.
REQ-007 SHALL drive in_ready registered as !(state==TWO); it SHALL NOT depend combinationally on out_ready.
REQ-008 SHALL follow these transitions:
- EMPTY+accept->ONE.
- ONE+accept without pop->TWO.
- ONE+pop without accept->EMPTY.
- ONE+accept+pop->ONE, with the new entry in main.
- TWO+pop->ONE, with the skid entry moved to main.
REQ-009 SHALL give one-cycle latency: an entry accepted at edge N is visible on out_* after edge N when the buffer was EMPTY, or when it was ONE with a pop at the same edge.
REQ-010 SHALL preserve order; an entry SHALL never be lost or duplicated without flush.
REQ-011 SHALL hold out_* stable while out_valid && !out_ready.
REQ-012 SHALL resolve a branch at acceptance:
- taken = is_branch && (ALU_operation==1 || (ALU_operation in 2..7 && ALU_result[0])).
- Any other ALU_operation with is_branch is not taken.
REQ-013 SHALL assert redirect_valid for exactly the cycle after a taken acceptance, with redirect_target = branch_target; otherwise redirect_valid=0 and redirect_target holds its last value.
REQ-014 SHALL still pass branch entries downstream unchanged, including regWrite for JAL/JALR.
REQ-015 SHALL give flush priority over all events: both entries invalidated, state EMPTY, same-cycle input discarded and not resolved, in_ready=1 next cycle.
REQ-016 SHALL NOT cancel a redirect pulse already asserted in the flush cycle.
REQ-017 SHALL pass all fields without modification or width change.

Reset
REQ-018 SHALL, at a reset edge, set state EMPTY, out_valid=0, redirect_valid=0, in_ready=1, and all out_* data and redirect_target to 0.
REQ-019 SHALL ignore in_valid, out_ready and flush while reset is high; reset mid-stall SHALL discard held entries.

Structure
REQ-020 SHALL take the ALU opcode constants (ADD=0, JAL=1, BEQ=2, BNE=3, BLT=4, BGE=5, BLTU=6, BGEU=7, ... SUB=14) from a shared package also used by the ALU and decode.
REQ-021 SHALL place the entry record width and the EMPTY/ONE/TWO state encoding in that package.
REQ-022 SHALL contain one sub-module, pipe_skid_buffer, parameterised on payload width; branch resolution stays in the top module.

Verification
REQ-023 Streaming: 8 back-to-back entries with out_ready=1, ALU_result=0x10..0x17 -> out_* carries 0x10..0x17 in order, one per cycle, 1-cycle latency, in_ready stays 1.
REQ-024 Backpressure: out_ready=0 for 4 cycles while 3 entries are offered -> 2 accepted, in_ready=0 after the second, out_* stable; release -> the third is accepted next cycle and the order is preserved.
REQ-025 Branch: BEQ (op 2) with ALU_result=1 and branch_target=0x00400 -> redirect_valid=1 for exactly one cycle with redirect_target=0x00400; BNE with ALU_result=0 -> no pulse; JAL (op 1) -> pulse.
REQ-026 Flush: buffer TWO, flush=1 while a taken BEQ is offered -> out_valid=0 and in_ready=1 next cycle, no redirect pulse, the discarded entry never appears.
REQ-027 Reset: reset asserted while in state TWO with out_ready=0 -> next cycle out_valid=0, redirect_valid=0, all outputs 0, in_ready=1.
